// File: rtl/fc_cmd_dispatch_if.sv
// ---------------------------------------------------------------------------
// fc_cmd_dispatch_if
//   Bundles the host-side FIFO push port and the FC-side command/done
//   handshake of fc_cmd_dispatch into one interface.
//
//   Signals:
//     push, push_cmd[32:0]   host -> dispatcher command write
//     full, ovf, level       FIFO status (level is AW+1 bits)
//     cmd[32:0], done        command bus to FC and FC's idle/finished level
//     busy, issued,          dispatcher status and one-cycle event pulses
//     complete, rej
//     start_err, cmd_cnt     sticky start timeout, completed-command count
//
//   Modports:
//     slave  - the dispatcher (takes push/push_cmd/done, drives the rest)
//     master - the environment (host + FC) around the dispatcher
// ---------------------------------------------------------------------------
interface fc_cmd_dispatch_if #(
  parameter int AW = 2
);
  logic          push;
  logic [32:0]   push_cmd;
  logic          full;
  logic          ovf;
  logic [32:0]   cmd;
  logic          done;
  logic          busy;
  logic          issued;
  logic          complete;
  logic          rej;
  logic          start_err;
  logic [AW:0]   level;
  logic [15:0]   cmd_cnt;

  modport slave (
    input  push, push_cmd, done,
    output full, ovf, cmd, busy, issued, complete, rej, start_err, level, cmd_cnt
  );

  modport master (
    output push, push_cmd, done,
    input  full, ovf, cmd, busy, issued, complete, rej, start_err, level, cmd_cnt
  );
endinterface

// File: rtl/fc_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// fc_cmd_dispatch
//   Upstream command source for the FC flash controller. Host commands are
//   queued in a DEPTH-entry FIFO; when FC reports done and the FIFO holds a
//   word, one word is popped. Illegal words (length 0, or A_memory+length
//   beyond 128) are discarded with a rej pulse; legal words are placed on
//   cmd with an issued pulse and tracked through FC's done handshake.
//
//   Command word: [32] dir, [31:14] A_flash, [13:7] A_memory, [6:0] length.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   fc_cmd_dispatch_if.slave (push side, FC side, status)
// ---------------------------------------------------------------------------
module fc_cmd_dispatch #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int START_TO = 64
) (
  input  logic               clk,
  input  logic               rst,
  fc_cmd_dispatch_if.slave   bus
);

  localparam int              CW        = $clog2(START_TO + 1);
  localparam logic [AW:0]     FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   START_LIM = CW'(START_TO - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2
  } state_t;

  // A word is legal when it moves at least one unit and stays inside the
  // 128-entry memory window; the sum is formed in 8 bits so it cannot wrap.
  function automatic logic cmd_legal(input logic [32:0] c);
    logic [7:0] sum;
    sum = {1'b0, c[13:7]} + {1'b0, c[6:0]};
    return (c[6:0] != 7'd0) && (sum <= 8'd128);
  endfunction

  logic [32:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          full_r;
  logic          ovf_r;
  logic [32:0]   cmd_r;
  logic          busy_r;
  logic          issued_r;
  logic          complete_r;
  logic          rej_r;
  logic          start_err_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   cmd_cnt_r;
  state_t        state_r;

  logic          push_ok_s;
  logic          empty_s;
  logic          pop_s;
  logic [32:0]   head_s;
  logic          legal_s;
  logic [AW:0]   level_nxt_s;

  // Push/pop qualification and next FIFO occupancy. Full is the registered
  // flag, so a push while full is refused even if a pop happens that cycle.
  always_comb begin
    push_ok_s   = bus.push & ~full_r;
    empty_s     = (level_r == {(AW+1){1'b0}});
    pop_s       = (state_r == IDLE) & bus.done & ~empty_s;
    head_s      = mem_r[rd_ptr_r];
    legal_s     = cmd_legal(head_s);
    level_nxt_s = level_r;
    case ({push_ok_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 33'd0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= bus.push_cmd;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == FULL_LVL);
      if (bus.push && full_r) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Dispatch FSM: screens the popped word, issues it, then follows FC's
  // done level (drop = started, rise = finished) with a start timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cmd_r       <= 33'd0;
      busy_r      <= 1'b0;
      issued_r    <= 1'b0;
      complete_r  <= 1'b0;
      rej_r       <= 1'b0;
      start_err_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      cmd_cnt_r   <= 16'd0;
    end else begin
      issued_r   <= 1'b0;
      complete_r <= 1'b0;
      rej_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            if (legal_s) begin
              cmd_r    <= head_s;
              issued_r <= 1'b1;
              busy_r   <= 1'b1;
              cnt_r    <= {CW{1'b0}};
              state_r  <= WAIT_START;
            end else begin
              rej_r <= 1'b1;
            end
          end
        end
        WAIT_START: begin
          if (!bus.done) begin
            state_r <= WAIT_DONE;
          end else if (cnt_r == START_LIM) begin
            start_err_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (bus.done) begin
            complete_r <= 1'b1;
            cmd_cnt_r  <= cmd_cnt_r + 16'd1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.full      = full_r;
  assign bus.ovf       = ovf_r;
  assign bus.cmd       = cmd_r;
  assign bus.busy      = busy_r;
  assign bus.issued    = issued_r;
  assign bus.complete  = complete_r;
  assign bus.rej       = rej_r;
  assign bus.start_err = start_err_r;
  assign bus.level     = level_r;
  assign bus.cmd_cnt   = cmd_cnt_r;

endmodule
